mem_dram_ctrl: RTL

MEM-stage data-memory controller: consumes the instruction fields presented by the EX/MEM pipeline register, runs loads and stores over a request/acknowledge bus to a variable-latency data RAM, and stalls the upstream pipeline while an access is outstanding. It registers the retiring instruction's write-back fields into the WB stage, and reports misaligned accesses and bus timeouts.

---
 rtl/mem_dram_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_dram_ctrl.sv
// MEM-stage data-memory controller: runs loads/stores over a req/ack bus to a
// variable-latency RAM, stalls the pipeline while busy and feeds the WB register.
module mem_dram_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_have_inst,
    input  logic        mem_rf_we,
    input  logic [1:0]  mem_wd_sel,
    input  logic        mem_dram_we,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_rD2,
    input  logic [4:0]  mem_wR,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_pc4,
    output logic        mem_stall,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        wb_have_inst,
    output logic        wb_rf_we,
    output logic [4:0]  wb_wR,
    output logic [31:0] wb_wD,
    output logic [31:0] wb_pc,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc
);

    // state  | meaning
    // S_IDLE | no access outstanding; decode the presented instruction
    // S_WAIT | bus request outstanding, waiting for dram_ack or timeout
    // S_RESP | access finished; retire the held instruction into WB
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TC = 8'(TIMEOUT - 1);
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;

    state_t      state, state_nxt;
    logic        ld, st, acc, mis;
    logic        launch, ack_hit, to_hit;
    logic [7:0]  cnt;
    logic        to_flag;
    logic [31:0] rdata_q;
    logic [31:0] wd_sel_data;

    assign ld  = mem_have_inst & mem_rf_we & (mem_wd_sel == 2'b01);
    assign st  = mem_have_inst & mem_dram_we;
    assign acc = ld | st;
    assign mis = acc & (mem_alu[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc && !mis) state_nxt = S_WAIT;
            S_WAIT:  if (dram_ack || cnt == TC) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        launch    = (state == S_IDLE) && acc && !mis;
        ack_hit   = (state == S_WAIT) && dram_ack;
        to_hit    = (state == S_WAIT) && !dram_ack && (cnt == TC);
        mem_stall = launch || (state == S_WAIT);
    end

    always_comb begin
        case (mem_wd_sel)
            2'b01:   wd_sel_data = rdata_q;
            2'b10:   wd_sel_data = mem_pc4;
            default: wd_sel_data = mem_alu;
        endcase
    end

    // Bus side: outputs stay frozen through WAIT; only dram_req drops on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dram_req   <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= 32'h0;
            dram_wdata <= 32'h0;
            cnt        <= 8'h0;
            to_flag    <= 1'b0;
            rdata_q    <= 32'h0;
        end else if (launch) begin
            dram_req   <= 1'b1;
            dram_we    <= st;
            dram_addr  <= mem_alu;
            dram_wdata <= mem_rD2;
            cnt        <= 8'h0;
            to_flag    <= 1'b0;
        end else if (ack_hit) begin
            rdata_q    <= dram_rdata;
            dram_req   <= 1'b0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 8'd1;
            if (to_hit) begin
                dram_req <= 1'b0;
                to_flag  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_have_inst <= 1'b0;
            wb_rf_we     <= 1'b0;
            wb_wR        <= 5'h0;
            wb_wD        <= 32'h0;
            wb_pc        <= 32'h0;
            err_valid    <= 1'b0;
            err_code     <= 2'b00;
            err_pc       <= 32'h0;
        end else if (mem_stall) begin
            wb_have_inst <= 1'b0;
            wb_rf_we     <= 1'b0;
            wb_wR        <= 5'h0;
            wb_wD        <= 32'h0;
            wb_pc        <= 32'h0;
            err_valid    <= 1'b0;
            err_code     <= 2'b00;
            err_pc       <= 32'h0;
        end else begin
            wb_have_inst <= mem_have_inst;
            wb_rf_we     <= mem_have_inst & mem_rf_we
                            & !((state == S_IDLE) && mis)
                            & !((state == S_RESP) && to_flag);
            wb_wR        <= mem_wR;
            wb_wD        <= wd_sel_data;
            wb_pc        <= mem_pc;
            if ((state == S_IDLE) && mis) begin
                err_valid <= 1'b1;
                err_code  <= ERR_MIS;
                err_pc    <= mem_pc;
            end else if ((state == S_RESP) && to_flag) begin
                err_valid <= 1'b1;
                err_code  <= ERR_TO;
                err_pc    <= mem_pc;
            end else begin
                err_valid <= 1'b0;
                err_code  <= 2'b00;
                err_pc    <= 32'h0;
            end
        end
    end

endmodule
